// File: rtl/spi_arb_pkg.sv
// Shared types and default widths for the SPI memory arbiter.
package spi_arb_pkg;

  localparam int unsigned ARB_ADDR_W         = 16;
  localparam int unsigned ARB_DATA_W         = 16;
  localparam int unsigned ARB_GAP_CYCLES     = 2;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 128;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RESP      = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester and SPI-controller signals of the arbiter, plus a debug view of its FSM state.
// Handshake: a requester holds *_req_i and its fields until the matching one-cycle *_done_o.
interface spi_mem_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_rwb_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_done_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              busy_o;
  logic              err_o;

  logic              mem_start_o;
  logic              mem_rwb_o;
  logic              mem_sel_dest_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_csb_i;
  logic [DATA_W-1:0] mem_inm_i;
  logic [DATA_W-1:0] mem_instr_i;

  arb_state_t        dbg_state_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_rwb_i, dm_addr_i, dm_wdata_i,
    input  mem_csb_i, mem_inm_i, mem_instr_i,
    output if_done_o, if_rdata_o, dm_done_o, dm_rdata_o, busy_o, err_o,
    output mem_start_o, mem_rwb_o, mem_sel_dest_o, mem_addr_o, mem_data_o,
    output dbg_state_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_rwb_i, dm_addr_i, dm_wdata_i,
    output mem_csb_i, mem_inm_i, mem_instr_i,
    input  if_done_o, if_rdata_o, dm_done_o, dm_rdata_o, busy_o, err_o,
    input  mem_start_o, mem_rwb_o, mem_sel_dest_o, mem_addr_o, mem_data_o,
    input  dbg_state_o
  );

endinterface

// File: rtl/spi_arb_rr2.sv
// Two-way round-robin pick between fetch and data requests; on a tie the side
// that was not served last wins.
module spi_arb_rr2
  import spi_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  grant_t last_grant_i,
  output logic   valid_o,
  output grant_t grant_o
);

  always_comb begin
    valid_o = if_req_i | dm_req_i;
    if (if_req_i && dm_req_i) begin
      grant_o = (last_grant_i == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
    end else if (dm_req_i) begin
      grant_o = GRANT_DATA;
    end else begin
      grant_o = GRANT_FETCH;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory controller between the CPU fetch and data ports.
// Optional macro SPI_ARB_TIMEOUT_EN bounds the chip-select waits and aborts with err_o.
module spi_mem_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int GAP_CYCLES     = ARB_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               reset,
  spi_mem_arbiter_if.slave  bus
);

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t        state_q, state_d;
  grant_t            grant_q, last_grant_q, pick_grant;
  logic              pick_valid;
  logic              rwb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic [GAP_W-1:0]  gap_q;
  logic              in_wait, tmo_hit, tmo_abort, done_pulse, resp_capture;
  arb_state_t        after_resp;

  spi_arb_rr2 u_rr2 (
    .if_req_i     (bus.if_req_i),
    .dm_req_i     (bus.dm_req_i),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  assign in_wait      = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);
  assign after_resp   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  // Read data is captured on the csb rising edge so it is valid alongside done.
  assign resp_capture = (state_q == ST_WAIT_HIGH) && bus.mem_csb_i;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= (in_wait && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;
    end
  end

  assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign tmo_abort  = tmo_hit &&
                      (((state_q == ST_WAIT_LOW)  &&  bus.mem_csb_i) ||
                       ((state_q == ST_WAIT_HIGH) && !bus.mem_csb_i));
  assign done_pulse = (state_q == ST_RESP) || tmo_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_FETCH;
      last_grant_q <= GRANT_FETCH;
      rwb_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      gap_q        <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && pick_valid) begin
        grant_q <= pick_grant;
        if (pick_grant == GRANT_DATA) begin
          rwb_q   <= bus.dm_rwb_i;
          addr_q  <= bus.dm_addr_i;
          wdata_q <= bus.dm_wdata_i;
        end else begin
          rwb_q   <= 1'b1;
          addr_q  <= bus.if_addr_i;
          wdata_q <= '0;
        end
      end
      if (resp_capture) begin
        if (grant_q == GRANT_FETCH) begin
          if_rdata_q <= bus.mem_instr_i;
        end else if (rwb_q) begin
          dm_rdata_q <= bus.mem_inm_i;
        end
      end
      if (done_pulse) begin
        last_grant_q <= grant_q;
      end
      gap_q <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!bus.mem_csb_i) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (bus.mem_csb_i) state_d = ST_RESP;
      ST_RESP:      state_d = after_resp;
      ST_GAP:       if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (tmo_abort) begin
      state_d = after_resp;
    end
  end

  always_comb begin
    bus.busy_o         = (state_q != ST_IDLE);
    bus.mem_start_o    = (state_q == ST_ISSUE);
    bus.if_done_o      = done_pulse && (grant_q == GRANT_FETCH);
    bus.dm_done_o      = done_pulse && (grant_q == GRANT_DATA);
    bus.err_o          = tmo_abort;
    bus.mem_rwb_o      = rwb_q;
    bus.mem_sel_dest_o = (grant_q == GRANT_DATA);
    bus.mem_addr_o     = addr_q;
    bus.mem_data_o     = wdata_q;
    bus.if_rdata_o     = if_rdata_q;
    bus.dm_rdata_o     = dm_rdata_q;
    bus.dbg_state_o    = state_q;
  end

endmodule
